// File: rtl/tile_pf_pkg.sv
// Tile prefetch buffer: shared constants
// and bank / fill state encodings.
package tile_pf_pkg;
  localparam int OUT_W   = 112;
  localparam int OUT_H   = 112;
  localparam int TILE_H  = 6;
  localparam int PADDING = 1;
  localparam int DATA_W  = 8;
  localparam int MAX_OUT = 4;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_READING
  } bank_st_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_ISSUE,
    F_DRAIN
  } fill_st_e;
endpackage

// File: rtl/tile_pf_if.sv
// Memory read port of the tile prefetch buffer:
// request/grant issue side, in-order response side.
interface tile_pf_if #(
  parameter int DATA_W = tile_pf_pkg::DATA_W
);
  logic              mem_req;
  logic [7:0]        mem_row;
  logic [7:0]        mem_col;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_row, mem_col,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_row, mem_col,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/tile_pf_addr_fifo.sv
// Bank-address FIFO pairing in-order read
// responses with the pixel slot they fill.
module tile_pf_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp;
  logic [PW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);
  assign dout  = mem[rp[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + (PW+1)'(1);
      if (pop && !empty)
        rp <= rp + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[PW-1:0]] <= din;
  end
endmodule

// File: rtl/tile_prefetch_buffer.sv
// Ping-pong tile buffer: fills one bank from memory
// (with zero padding) while the scanner reads the other.
module tile_prefetch_buffer #(
  parameter int OUT_W   = tile_pf_pkg::OUT_W,
  parameter int OUT_H   = tile_pf_pkg::OUT_H,
  parameter int TILE_H  = tile_pf_pkg::TILE_H,
  parameter int PADDING = tile_pf_pkg::PADDING,
  parameter int DATA_W  = tile_pf_pkg::DATA_W,
  parameter int MAX_OUT = tile_pf_pkg::MAX_OUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                cfg_w,
  input  logic [7:0]                cfg_h,
  input  logic                      stride2_en,
  input  logic                      tile_start,
  input  logic [$clog2(OUT_H)-1:0]  tile_row,
  tile_pf_if.master                 mem,
  output logic                      buffer_ready,
  input  logic                      read_enable,
  input  logic [$clog2(OUT_W)-1:0]  read_addr,
  output logic [TILE_H*DATA_W-1:0]  col_data,
  output logic                      col_valid,
  output logic                      overflow
);
  import tile_pf_pkg::*;

  localparam int RW = $clog2(OUT_H);
  localparam int CW = $clog2(OUT_W);
  localparam int IW = $clog2(TILE_H);
  localparam int AW = 1 + IW + CW;
  localparam int NW = $clog2(MAX_OUT + 1);
  localparam logic [7:0]    W_MAX   = 8'(OUT_W - 2*PADDING);
  localparam logic [7:0]    H_MAX   = 8'(OUT_H);
  localparam logic [7:0]    PW2     = 8'(2*PADDING);
  localparam logic [8:0]    PAD9    = 9'(PADDING);
  localparam logic [NW-1:0] OUT_LIM = NW'(MAX_OUT);

  fill_st_e          fst, fnext;
  bank_st_e          bst [2];
  logic [7:0]        pw [2];
  logic [7:0]        fill_w, fill_h;
  logic              fill_bank;
  logic [RW-1:0]     base_row;
  logic [IW-1:0]     row_i;
  logic [7:0]        col_c;
  logic [NW-1:0]     outst;
  logic              pend_v;
  logic [RW-1:0]     pend_row;
  logic [DATA_W-1:0] bank_mem [2][TILE_H][OUT_W];

  logic [7:0]    w_c, h_c, fill_pw;
  logic          has_empty, empty_sel;
  logic          start;
  logic [RW-1:0] start_row;
  logic [8:0]    r_p, c_p;
  logic          pad, last_px;
  logic          advance, pad_wr, drain_done;
  logic          grant, rv;
  logic          fifo_empty, fifo_full;
  logic [AW-1:0] fill_addr, fifo_dout;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic          rd_bank, rd_last, rd_fire, rel;
  logic [8:0]    rd_lim;
  logic          swap, swap_sel;

  assign w_c = (cfg_w > W_MAX) ? W_MAX : cfg_w;
  assign h_c = (cfg_h > H_MAX) ? H_MAX : cfg_h;

  assign has_empty = (bst[0] == B_EMPTY) || (bst[1] == B_EMPTY);
  assign empty_sel = (bst[0] == B_EMPTY) ? 1'b0 : 1'b1;
  assign start     = (fst == F_IDLE) && has_empty &&
                     (pend_v || tile_start);
  assign start_row = pend_v ? pend_row : tile_row;

  assign fill_pw = fill_w + PW2;
  assign r_p     = 9'(base_row) + 9'(row_i);
  assign c_p     = {1'b0, col_c};
  assign pad     = (r_p < PAD9) ||
                   (r_p >= 9'(fill_h) + PAD9) ||
                   (c_p < PAD9) ||
                   (c_p >= 9'(fill_w) + PAD9);
  assign last_px = (row_i == IW'(TILE_H - 1)) &&
                   (col_c == fill_pw - 8'd1);

  always_comb begin
    fnext       = fst;
    mem.mem_req = 1'b0;
    advance     = 1'b0;
    pad_wr      = 1'b0;
    drain_done  = 1'b0;
    unique case (fst)
      F_IDLE: begin
        if (start)
          fnext = F_ISSUE;
      end
      F_ISSUE: begin
        if (pad) begin
          // one write port: a response always wins
          pad_wr  = !mem.mem_rvalid;
          advance = pad_wr;
        end else begin
          mem.mem_req = (outst != OUT_LIM) && !fifo_full;
          advance     = mem.mem_req && mem.mem_gnt;
        end
        if (advance && last_px)
          fnext = F_DRAIN;
      end
      F_DRAIN: begin
        if (outst == '0) begin
          fnext      = F_IDLE;
          drain_done = 1'b1;
        end
      end
      default: fnext = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fst <= F_IDLE;
    else
      fst <= fnext;
  end

  assign mem.mem_row = mem.mem_req ? 8'(r_p - PAD9) : '0;
  assign mem.mem_col = mem.mem_req ? 8'(c_p - PAD9) : '0;

  assign grant     = mem.mem_req && mem.mem_gnt;
  // responses with nothing pending are stale
  assign rv        = mem.mem_rvalid && !fifo_empty;
  assign fill_addr = {fill_bank, row_i, col_c[CW-1:0]};

  tile_pf_addr_fifo #(
    .DEPTH (MAX_OUT),
    .W     (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .pop   (rv),
    .din   (fill_addr),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign wr_en   = rv || pad_wr;
  assign wr_addr = rv ? fifo_dout : fill_addr;
  assign wr_data = rv ? mem.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (wr_en)
      bank_mem[wr_addr[AW-1]][wr_addr[CW +: IW]]
              [wr_addr[CW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_w    <= '0;
      fill_h    <= '0;
      fill_bank <= 1'b0;
      base_row  <= '0;
      row_i     <= '0;
      col_c     <= '0;
    end else if (start) begin
      fill_w    <= w_c;
      fill_h    <= h_c;
      fill_bank <= empty_sel;
      base_row  <= start_row;
      row_i     <= '0;
      col_c     <= '0;
    end else if (advance) begin
      if (col_c == fill_pw - 8'd1) begin
        col_c <= '0;
        row_i <= row_i + IW'(1);
      end else begin
        col_c <= col_c + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      unique case ({grant, rv})
        2'b10:   outst <= outst + NW'(1);
        2'b01:   outst <= outst - NW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_row <= '0;
      overflow <= 1'b0;
    end else if (start && pend_v) begin
      // slot drains into the fill; a new pulse refills it
      pend_v <= tile_start;
      if (tile_start)
        pend_row <= tile_row;
    end else if (start) begin
      pend_v <= 1'b0;
    end else if (tile_start && pend_v) begin
      overflow <= 1'b1;
    end else if (tile_start) begin
      pend_v   <= 1'b1;
      pend_row <= tile_row;
    end
  end

  assign buffer_ready = (bst[0] == B_READING) ||
                        (bst[1] == B_READING);
  assign rd_bank  = (bst[1] == B_READING);
  assign rd_lim   = {1'b0, pw[rd_bank]};
  assign rd_last  = stride2_en ?
                    (9'(read_addr) + 9'd2 >= rd_lim) :
                    (9'(read_addr) + 9'd1 >= rd_lim);
  assign rd_fire  = read_enable && buffer_ready;
  assign rel      = rd_fire && rd_last;
  assign swap     = !buffer_ready &&
                    ((bst[0] == B_FULL) || (bst[1] == B_FULL));
  assign swap_sel = (bst[0] == B_FULL) ? 1'b0 : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst[0] <= B_EMPTY;
      bst[1] <= B_EMPTY;
      pw[0]  <= '0;
      pw[1]  <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        unique case (1'b1)
          start && (empty_sel == 1'(b)): begin
            bst[b] <= B_FILLING;
            pw[b]  <= w_c + PW2;
          end
          drain_done && (fill_bank == 1'(b)):
            bst[b] <= B_FULL;
          rel && (rd_bank == 1'(b)):
            bst[b] <= B_EMPTY;
          swap && (swap_sel == 1'(b)):
            bst[b] <= B_READING;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_valid <= 1'b0;
      col_data  <= '0;
    end else begin
      col_valid <= rd_fire;
      if (rd_fire) begin
        for (int i = 0; i < TILE_H; i++)
          col_data[i*DATA_W +: DATA_W] <=
            bank_mem[rd_bank][i][read_addr];
      end
    end
  end
endmodule

// File: tb/tb_tile_prefetch_buffer.sv
// Directed bench for tile_prefetch_buffer with a
// latency-programmable in-order memory model.
module tb_tile_prefetch_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_w = '0;
  logic [7:0]  cfg_h = '0;
  logic        stride2_en = 1'b0;
  logic        tile_start = 1'b0;
  logic [6:0]  tile_row = '0;
  logic        buffer_ready;
  logic        read_enable = 1'b0;
  logic [6:0]  read_addr = '0;
  logic [47:0] col_data;
  logic        col_valid;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic        gnt_en = 1'b1;
  int unsigned lat = 2;
  int unsigned cyc_m = 0;
  int          b_out = 0;
  int          max_out = 0;
  int          ngrant = 0;
  logic        bad_row = 1'b0;

  typedef struct {
    logic [7:0]  d;
    int unsigned due;
  } rsp_t;
  rsp_t rq[$];

  always #5 clk = ~clk;

  tile_pf_if mem_if ();

  tile_prefetch_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_w        (cfg_w),
    .cfg_h        (cfg_h),
    .stride2_en   (stride2_en),
    .tile_start   (tile_start),
    .tile_row     (tile_row),
    .mem          (mem_if.master),
    .buffer_ready (buffer_ready),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .col_data     (col_data),
    .col_valid    (col_valid),
    .overflow     (overflow)
  );

  assign mem_if.mem_gnt = gnt_en;

  // memory returns row*16+col, in order, lat cycles after grant
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.delete();
      b_out = 0;
      mem_if.mem_rvalid <= 1'b0;
      mem_if.mem_rdata  <= '0;
    end else begin
      cyc_m = cyc_m + 1;
      if (mem_if.mem_rvalid)
        b_out = b_out - 1;
      if (mem_if.mem_req && mem_if.mem_gnt) begin
        b_out  = b_out + 1;
        ngrant = ngrant + 1;
        if (mem_if.mem_row >= 8'd39 && mem_if.mem_row <= 8'd44)
          bad_row = 1'b1;
        rq.push_back('{
          d:   8'((int'(mem_if.mem_row) * 16 +
                   int'(mem_if.mem_col)) & 255),
          due: cyc_m + lat});
      end
      if (b_out > max_out)
        max_out = b_out;
      if (rq.size() > 0 && rq[0].due <= cyc_m) begin
        mem_if.mem_rvalid <= 1'b1;
        mem_if.mem_rdata  <= rq[0].d;
        void'(rq.pop_front());
      end else begin
        mem_if.mem_rvalid <= 1'b0;
      end
    end
  end

  function automatic logic [47:0] exp_col(
    int base, int c, int w, int h);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) begin
      int r;
      r = base + i;
      if (r >= 1 && r < h + 1 && c >= 1 && c < w + 1)
        v[i*8 +: 8] = 8'(((r - 1) * 16 + (c - 1)) & 255);
    end
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_tile(input int row);
    @(negedge clk);
    tile_start = 1'b1;
    tile_row   = 7'(row);
    @(negedge clk);
    tile_start = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (!buffer_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(buffer_ready), 64'd1);
  endtask

  task automatic rd(input int a, input logic [47:0] e,
                    input string tag);
    @(negedge clk);
    read_enable = 1'b1;
    read_addr   = 7'(a);
    @(negedge clk);
    read_enable = 1'b0;
    chk({tag, "_v"}, 64'(col_valid), 64'd1);
    chk(tag, 64'(col_data), 64'(e));
  endtask

  logic [47:0] got [16];
  int ngot, nrd, gap, a, g0;
  logic seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(mem_if.mem_req), 64'd0);
    chk("rst_row", 64'(mem_if.mem_row), 64'd0);
    chk("rst_col", 64'(mem_if.mem_col), 64'd0);
    chk("rst_ready", 64'(buffer_ready), 64'd0);
    chk("rst_valid", 64'(col_valid), 64'd0);
    chk("rst_data", 64'(col_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    // corner padding: 4x4 image, tile at row 0
    cfg_w = 8'd4;
    cfg_h = 8'd4;
    lat   = 2;
    g0    = ngrant;
    start_tile(0);
    wait_ready("a_ready", 300);
    chk("a_nreq", 64'(ngrant - g0), 64'd16);
    rd(0, 48'h0, "a_c0");
    rd(1, 48'h00_30_20_10_00_00, "a_c1");
    rd(4, 48'h00_33_23_13_03_00, "a_c4");
    rd(5, 48'h0, "a_c5");
    chk("a_release", 64'(buffer_ready), 64'd0);

    // ping-pong with a continuously reading scanner
    cfg_h = 8'd7;
    @(negedge clk);
    tile_start = 1'b1;
    tile_row   = 7'd0;
    @(negedge clk);
    tile_row   = 7'd4;
    @(negedge clk);
    tile_start = 1'b0;
    repeat (200) @(negedge clk);
    ngot = 0; nrd = 0; gap = 0; a = 0; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (col_valid && ngot < 16) begin
        got[ngot] = col_data;
        ngot++;
      end
      if (buffer_ready)
        seen = 1'b1;
      else if (seen && nrd < 12)
        gap++;
      if (buffer_ready && nrd < 12) begin
        read_enable = 1'b1;
        read_addr   = 7'(a);
        a   = (a == 5) ? 0 : a + 1;
        nrd++;
      end else begin
        read_enable = 1'b0;
      end
    end
    read_enable = 1'b0;
    chk("pp_ncols", 64'(ngot), 64'd12);
    chk("pp_gap", 64'(gap), 64'd1);
    chk("pp_t0c1", 64'(got[1]), 64'(exp_col(0, 1, 4, 7)));
    chk("pp_t1c0", 64'(got[6]), 64'd0);
    chk("pp_t1c1", 64'(got[7]), 64'(48'h00_00_60_50_40_30));
    chk("pp_t1c4", 64'(got[10]), 64'(exp_col(4, 4, 4, 7)));

    // backpressure: no grant for 20 cycles, then 3-cycle latency
    cfg_w  = 8'd6;
    cfg_h  = 8'd10;
    gnt_en = 1'b0;
    lat    = 3;
    start_tile(2);
    repeat (20) @(negedge clk);
    chk("bp_req", 64'(mem_if.mem_req), 64'd1);
    chk("bp_row", 64'(mem_if.mem_row), 64'd1);
    chk("bp_col", 64'(mem_if.mem_col), 64'd0);
    chk("bp_none", 64'(b_out), 64'd0);
    gnt_en = 1'b1;
    wait_ready("bp_ready", 400);
    rd(0, 48'h0, "bp_c0");
    rd(3, exp_col(2, 3, 6, 10), "bp_c3");
    rd(6, exp_col(2, 6, 6, 10), "bp_c6");
    rd(7, 48'h0, "bp_c7");
    chk("bp_release", 64'(buffer_ready), 64'd0);

    // stride 2: padded_w 8, released by addr 6
    cfg_h      = 8'd4;
    lat        = 2;
    stride2_en = 1'b1;
    start_tile(0);
    wait_ready("s2_ready", 300);
    rd(0, 48'h0, "s2_c0");
    rd(2, exp_col(0, 2, 6, 4), "s2_c2");
    rd(4, exp_col(0, 4, 6, 4), "s2_c4");
    chk("s2_hold", 64'(buffer_ready), 64'd1);
    rd(6, exp_col(0, 6, 6, 4), "s2_c6");
    chk("s2_release", 64'(buffer_ready), 64'd0);
    stride2_en = 1'b0;

    // overflow: read bank full, fill busy, three pulses
    cfg_w = 8'd4;
    cfg_h = 8'd50;
    start_tile(0);
    wait_ready("ov_ready0", 300);
    @(negedge clk);
    tile_start = 1'b1;
    tile_row   = 7'd10;
    @(negedge clk);
    tile_row   = 7'd20;
    @(negedge clk);
    tile_row   = 7'd40;
    @(negedge clk);
    tile_start = 1'b0;
    chk("ov_flag", 64'(overflow), 64'd1);
    repeat (150) @(negedge clk);
    rd(5, 48'h0, "ov_t0c5");
    wait_ready("ov_ready1", 300);
    rd(1, exp_col(10, 1, 4, 50), "ov_t1c1");
    rd(5, 48'h0, "ov_t1c5");
    wait_ready("ov_ready2", 300);
    rd(1, exp_col(20, 1, 4, 50), "ov_t2c1");
    rd(5, 48'h0, "ov_t2c5");
    repeat (150) @(negedge clk);
    chk("ov_no_third", 64'(buffer_ready), 64'd0);
    chk("ov_row40", 64'(bad_row), 64'd0);
    chk("ov_sticky", 64'(overflow), 64'd1);

    // reset with three reads in flight
    cfg_h = 8'd4;
    lat   = 8;
    start_tile(0);
    for (int n = 0; n < 100 && b_out != 3; n++)
      @(negedge clk);
    chk("mr_out3", 64'(b_out), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mr_req", 64'(mem_if.mem_req), 64'd0);
    chk("mr_row", 64'(mem_if.mem_row), 64'd0);
    chk("mr_col", 64'(mem_if.mem_col), 64'd0);
    chk("mr_ready", 64'(buffer_ready), 64'd0);
    chk("mr_valid", 64'(col_valid), 64'd0);
    chk("mr_data", 64'(col_data), 64'd0);
    chk("mr_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat   = 2;
    g0    = ngrant;
    start_tile(0);
    wait_ready("mr_ready2", 300);
    chk("mr_nreq", 64'(ngrant - g0), 64'd16);
    rd(1, 48'h00_30_20_10_00_00, "mr_c1");
    rd(4, 48'h00_33_23_13_03_00, "mr_c4");
    rd(5, 48'h0, "mr_c5");

    chk("max_outstanding", 64'(max_out <= 4), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
